// File: rtl/line_scheduler.sv
// ---------------------------------------------------------------------------
// line_scheduler
//
// Sequences the dual-bank line buffer of the video output path. The write
// side counts the qualified pixels of each incoming line. The hsync rising
// edge swaps the banks and latches that count as the width of the line that
// is about to be read back. The width is classified into an output target
// width (256/360/512, slot code 0/2/4), and the centering border is derived
// from it. An output FSM then produces the delayed hsync, the de window,
// the FIFO pop and the pixel-source select for the line buffer datapath.
//
// Ports
//   clk_vid      in   video clock (only clock)
//   reset        in   synchronous, active-high
//   hsync_in     in   core hsync, rising edge ends a line
//   vsync_in     in   core vsync
//   ce_pix       in   pixel strobe
//   disable_pix  in   suppresses the pixel at ce_pix
//   fifo_empty   in   empty flag of the bank being read
//   write_en     out  write strobe to the bank being written (ce_pix + 1)
//   bank_sel     out  0: read bank0 / write bank1, 1: the reverse
//   read_ack     out  pop of the read bank (show-ahead FIFO)
//   de           out  output data enable
//   px_sel       out  0 black, 1 FIFO data, 2 slot code
//   slot         out  resolution slot code (0/2/4)
//   line_width   out  latched pixel count of the line being read
//   hsync_out    out  one-cycle output hsync pulse
//   vsync_out    out  one-cycle vsync rising-edge pulse
//
// Build option
//   LINE_SCHED_HYSTERESIS_EN  when defined, the width class (target/slot)
//   only changes after STABLE_LINES consecutive lines of the same new class.
//   When undefined, the class follows every latched width immediately.
//
// Output FSM
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | nothing to show, waits for the next hsync edge
//   ST_HS_WAIT  | counting down the output-line start delay
//   ST_BORDER_L | left black border, border cycles
//   ST_ACTIVE   | popping FIFO data until the bank runs empty
//   ST_BORDER_R | right black border, border cycles
//   ST_TAIL     | one cycle presenting the slot code, de low
// ---------------------------------------------------------------------------
module line_scheduler #(
  parameter int HS_DELAY     = 15,
  parameter int HS_OFFSET    = 6,
  parameter int STABLE_LINES = 4
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       ce_pix,
  input  logic       disable_pix,
  input  logic       fifo_empty,
  output logic       write_en,
  output logic       bank_sel,
  output logic       read_ack,
  output logic       de,
  output logic [1:0] px_sel,
  output logic [3:0] slot,
  output logic [9:0] line_width,
  output logic       hsync_out,
  output logic       vsync_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HS_WAIT  = 3'd1,
    ST_BORDER_L = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_BORDER_R = 3'd4,
    ST_TAIL     = 3'd5
  } state_t;

`ifdef LINE_SCHED_HYSTERESIS_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam logic [7:0] HS_LOAD  = 8'(HS_DELAY);
  localparam logic [7:0] HS_PULSE = 8'(HS_DELAY - HS_OFFSET);
  localparam logic [7:0] STABLE_N = 8'(STABLE_LINES);
  localparam logic [9:0] PIX_MAX  = 10'd1023;

  localparam logic [1:0] CLS_256 = 2'd0;
  localparam logic [1:0] CLS_360 = 2'd1;
  localparam logic [1:0] CLS_512 = 2'd2;

  localparam logic [1:0] PX_BLACK = 2'd0;
  localparam logic [1:0] PX_DATA  = 2'd1;
  localparam logic [1:0] PX_SLOT  = 2'd2;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic       prev_hsync_q, prev_vsync_q;
  logic       write_en_q;
  logic       bank_sel_q;
  logic [9:0] pix_cnt_q;
  logic [9:0] line_width_q;
  logic [1:0] cls_q, cls_d;
  logic [1:0] cand_cls_q, cand_cls_d;
  logic [7:0] stable_cnt_q, stable_cnt_d;
  state_t     state_q, state_d;
  logic [7:0] hs_cnt_q, hs_cnt_d;
  logic [8:0] bord_cnt_q, bord_cnt_d;

  // -------------------------------------------------------------------------
  // Edge detect and write side
  // -------------------------------------------------------------------------
  logic       pix_ok;
  logic       hs_edge;
  logic [9:0] pix_cnt_inc;

  assign pix_ok  = ce_pix & ~disable_pix;
  assign hs_edge = hsync_in & ~prev_hsync_q;

  // Count including the current pixel, so a pixel coincident with the
  // hsync edge still lands in the width latched for that line.
  assign pix_cnt_inc = (pix_ok && (pix_cnt_q != PIX_MAX)) ? pix_cnt_q + 10'd1 : pix_cnt_q;

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      prev_hsync_q <= 1'b0;
      prev_vsync_q <= 1'b0;
      write_en_q   <= 1'b0;
      bank_sel_q   <= 1'b0;
      pix_cnt_q    <= '0;
      line_width_q <= '0;
    end else begin
      prev_hsync_q <= hsync_in;
      prev_vsync_q <= vsync_in;
      write_en_q   <= pix_ok;
      if (hs_edge) begin
        bank_sel_q   <= ~bank_sel_q;
        line_width_q <= pix_cnt_inc;
        pix_cnt_q    <= '0;
      end else begin
        pix_cnt_q    <= pix_cnt_inc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Width classification
  // -------------------------------------------------------------------------
  function automatic logic [1:0] classify(input logic [9:0] width);
    if (width < 10'd280)      return CLS_256;
    else if (width < 10'd380) return CLS_360;
    else                      return CLS_512;
  endfunction

  logic [1:0] new_cls;
  logic [7:0] run_len;

  // The class is evaluated on the width being latched, so target and slot
  // move on the same clock as line_width.
  assign new_cls = classify(pix_cnt_inc);

  always_comb begin
    cls_d        = cls_q;
    cand_cls_d   = cand_cls_q;
    stable_cnt_d = stable_cnt_q;
    // Length of the run of lines in the candidate class including this one.
    run_len = ((new_cls == cand_cls_q) && (stable_cnt_q != 8'd0)) ? stable_cnt_q + 8'd1 : 8'd1;
    if (hs_edge) begin
      if (!HYST_EN) begin
        cls_d = new_cls;
      end else if (new_cls == cls_q) begin
        stable_cnt_d = 8'd0;
      end else if (run_len >= STABLE_N) begin
        cls_d        = new_cls;
        stable_cnt_d = 8'd0;
      end else begin
        cand_cls_d   = new_cls;
        stable_cnt_d = run_len;
      end
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      cls_q        <= CLS_256;
      cand_cls_q   <= CLS_256;
      stable_cnt_q <= '0;
    end else begin
      cls_q        <= cls_d;
      cand_cls_q   <= cand_cls_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  logic [9:0] target_w;
  logic [9:0] short_by;
  logic [8:0] border;

  always_comb begin
    case (cls_q)
      CLS_256: target_w = 10'd256;
      CLS_360: target_w = 10'd360;
      default: target_w = 10'd512;
    endcase
  end

  assign short_by = (target_w > line_width_q) ? target_w - line_width_q : 10'd0;
  assign border   = short_by[9:1];

  // -------------------------------------------------------------------------
  // Output FSM
  // -------------------------------------------------------------------------
  logic       de_c;
  logic       read_ack_c;
  logic [1:0] px_sel_c;

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hs_cnt_q   <= '0;
      bord_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hs_cnt_q   <= hs_cnt_d;
      bord_cnt_q <= bord_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hs_cnt_d   = hs_cnt_q;
    bord_cnt_d = bord_cnt_q;
    de_c       = 1'b0;
    read_ack_c = 1'b0;
    px_sel_c   = PX_BLACK;

    case (state_q)
      ST_IDLE: begin
      end

      ST_HS_WAIT: begin
        hs_cnt_d = (hs_cnt_q != 8'd0) ? hs_cnt_q - 8'd1 : 8'd0;
        // Leave while the counter steps to 0 so the first border/active
        // cycle lands exactly HS_DELAY cycles after the load.
        if (hs_cnt_q <= 8'd1) begin
          bord_cnt_d = '0;
          state_d    = (border == 9'd0) ? ST_ACTIVE : ST_BORDER_L;
        end
      end

      ST_BORDER_L: begin
        de_c       = 1'b1;
        bord_cnt_d = bord_cnt_q + 9'd1;
        if ((bord_cnt_q + 9'd1) >= border) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (!fifo_empty) begin
          de_c       = 1'b1;
          px_sel_c   = PX_DATA;
          read_ack_c = 1'b1;
        end else begin
          bord_cnt_d = '0;
          state_d    = ST_BORDER_R;
        end
      end

      ST_BORDER_R: begin
        if (bord_cnt_q < border) begin
          de_c       = 1'b1;
          bord_cnt_d = bord_cnt_q + 9'd1;
          if ((bord_cnt_q + 9'd1) >= border) begin
            state_d = ST_TAIL;
          end
        end else begin
          state_d = ST_TAIL;
        end
      end

      ST_TAIL: begin
        px_sel_c = PX_SLOT;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new line always restarts the output sequence; outputs of the
    // current cycle are left alone so they drop one cycle later.
    if (hs_edge) begin
      state_d    = ST_HS_WAIT;
      hs_cnt_d   = HS_LOAD;
      bord_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign write_en   = write_en_q;
  assign bank_sel   = bank_sel_q;
  assign read_ack   = read_ack_c;
  assign de         = de_c;
  assign px_sel     = px_sel_c;
  assign slot       = {1'b0, cls_q, 1'b0};
  assign line_width = line_width_q;
  assign hsync_out  = (state_q == ST_HS_WAIT) && (hs_cnt_q == HS_PULSE);
  assign vsync_out  = vsync_in & ~prev_vsync_q;

endmodule
